// File: rtl/rls_result_drain.sv
// rls_result_drain: captures RLS solution words into a circular buffer and streams them out with block markers.
// Define RLS_DRAIN_TAG_EN to add rd_tag, the low 16 bits of the head word's block index.
module rls_result_drain #(
   parameter int N     = 16,
   parameter int W     = 32,
   parameter int DEPTH = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         write,
   input  logic [W-1:0] xin,
   input  logic         seq_final,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   output logic         rd_last,
   input  logic         rd_ready,
   output logic [31:0]  blocks_done,
   output logic         overflow,
   output logic         len_err,
`ifdef RLS_DRAIN_TAG_EN
   output logic [15:0]  rd_tag,
`endif
   output logic         done
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(N + 1);
`ifdef RLS_DRAIN_TAG_EN
   localparam int MW = W + 17;
`else
   localparam int MW = W + 1;
`endif
   localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   logic [MW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   occ_q, occ_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic [31:0]   blocks_q, blocks_d;
   logic          overflow_q, overflow_d;
   logic          len_err_q, len_err_d;
   logic          final_seen_q, final_seen_d;
   logic          push, pop, is_last;
   logic [MW-1:0] wr_word, head;

   assign head     = mem[rptr_q];
   assign rd_valid = (occ_q != '0);
   assign pop      = rd_valid && rd_ready;
   // A full buffer still accepts a word when the head leaves in the same cycle.
   assign push     = write && ((occ_q != OCC_FULL) || pop);
   assign is_last  = write && (wcnt_q == LAST_CNT);

`ifdef RLS_DRAIN_TAG_EN
   assign wr_word = {blocks_q[15:0], is_last, xin};
   assign rd_tag  = rd_valid ? head[W+16:W+1] : 16'd0;
`else
   assign wr_word = {is_last, xin};
`endif

   assign rd_data     = rd_valid ? head[W-1:0] : '0;
   assign rd_last     = rd_valid && head[W];
   assign blocks_done = blocks_q;
   assign overflow    = overflow_q;
   assign len_err     = len_err_q;
   assign done        = final_seen_q && (occ_q == '0);

   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      wcnt_d       = wcnt_q;
      blocks_d     = blocks_q;
      overflow_d   = overflow_q;
      len_err_d    = len_err_q;
      final_seen_d = final_seen_q || seq_final;
      occ_d        = occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (write) begin
         // Framing advances even for dropped words so later blocks stay aligned.
         if (is_last) begin
            wcnt_d   = '0;
            blocks_d = blocks_q + 32'd1;
         end else begin
            wcnt_d = wcnt_q + CW'(1);
         end
         if (!push) overflow_d = 1'b1;
      end else if (wcnt_q != '0) begin
         len_err_d = 1'b1;
         wcnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         occ_q        <= '0;
         wcnt_q       <= '0;
         blocks_q     <= '0;
         overflow_q   <= 1'b0;
         len_err_q    <= 1'b0;
         final_seen_q <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         occ_q        <= occ_d;
         wcnt_q       <= wcnt_d;
         blocks_q     <= blocks_d;
         overflow_q   <= overflow_d;
         len_err_q    <= len_err_d;
         final_seen_q <= final_seen_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= wr_word;
   end
endmodule

// File: tb/tb_rls_result_drain.sv
// Directed bench for rls_result_drain: per-cycle vector table plus sequences for overflow, wrap, completion and reset.
module tb_rls_result_drain;
   localparam int N = 16, W = 32, DEPTH = 64;

   logic          clk = 1'b0, reset = 1'b0, write = 1'b0, seq_final = 1'b0, rd_ready = 1'b0;
   logic [W-1:0]  xin = '0;
   logic [W-1:0]  rd_data;
   logic          rd_valid, rd_last, overflow, len_err, done;
   logic [31:0]   blocks_done;
`ifdef RLS_DRAIN_TAG_EN
   logic [15:0]   rd_tag;
`endif
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   rls_result_drain #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .write(write), .xin(xin), .seq_final(seq_final),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
      .blocks_done(blocks_done), .overflow(overflow), .len_err(len_err),
`ifdef RLS_DRAIN_TAG_EN
      .rd_tag(rd_tag),
`endif
      .done(done)
   );

   typedef struct {
      logic         rst, wr, rdy, fin;
      logic [W-1:0] x;
      logic         ev;
      logic [W-1:0] ed;
      logic         el;
      logic [31:0]  eb;
      logic         elen, edone;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(logic rst, wr, rdy, fin, logic [W-1:0] x, logic ev,
                               logic [W-1:0] ed, logic el, logic [31:0] eb, logic elen, logic edone);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rdy = rdy; v.fin = fin; v.x = x;
      v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.elen = elen; v.edone = edone;
      vecs.push_back(v);
   endfunction

   task automatic apply(input vec_t v, input int idx);
      write = v.wr; xin = v.x; rd_ready = v.rdy; seq_final = v.fin;
      if (v.rst) reset = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", idx), rd_valid, v.ev);
      chk($sformatf("v%0d data", idx), rd_data, v.ed);
      chk($sformatf("v%0d last", idx), rd_last, v.el);
      chk($sformatf("v%0d blocks", idx), blocks_done, v.eb);
      chk($sformatf("v%0d len_err", idx), len_err, v.elen);
      chk($sformatf("v%0d overflow", idx), overflow, 1'b0);
      chk($sformatf("v%0d done", idx), done, v.edone);
      reset = 1'b1;
   endtask

   task automatic do_reset();
      write = 1'b0; rd_ready = 1'b0; seq_final = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops, sent, got, n;

      // rst wr rdy fin x | ev ed el eb elen edone
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 16; i++) add(0, 1, 1, 0, i, 1, i, i == 16, (i == 16) ? 1 : 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) add(0, 1, 1, 0, 100 + i, 1, 100 + i, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 16; i++) add(0, 1, 1, 0, 200 + i, 1, 200 + i, i == 16, (i == 16) ? 1 : 0, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
      for (int i = 1; i <= 20; i++) add(0, 1, 1, 0, 300 + i, 1, 300 + i, i == 16, (i >= 16) ? 2 : 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 1);
      foreach (vecs[i]) apply(vecs[i], i);

      // Backpressure: five blocks into a 64-deep buffer, then drain.
      do_reset();
      for (int i = 1; i <= 80; i++) begin
         write = 1'b1; xin = i;
         cyc();
         if (i == 64) chk("ovf_at_64", overflow, 1'b0);
         if (i == 65) chk("ovf_at_65", overflow, 1'b1);
      end
      write = 1'b0;
      cyc();
      chk("ovf_blocks", blocks_done, 32'd5);
      chk("ovf_sticky", overflow, 1'b1);
      chk("ovf_len_err", len_err, 1'b0);
      rd_ready = 1'b1;
      pops = 0;
      for (int c = 0; c < 100 && rd_valid; c++) begin
         chk($sformatf("ovf_data%0d", pops), rd_data, pops + 1);
         chk($sformatf("ovf_last%0d", pops), rd_last, ((pops + 1) % 16) == 0);
         pops++;
         cyc();
      end
      chk("ovf_pop_count", pops, 64);
      chk("ovf_empty", rd_valid, 1'b0);

      // Wrap: ten blocks with idle gaps, consumer ready every other cycle.
      do_reset();
      sent = 0; got = 0; n = 0;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < 32; c++) begin
            write = (c < 16);
            xin = 1000 + sent;
            rd_ready = (n % 2) == 0;
            if (rd_valid && rd_ready) begin
               chk($sformatf("wrap_data%0d", got), rd_data, 1000 + got);
               chk($sformatf("wrap_last%0d", got), rd_last, (got % 16) == 15);
               got++;
            end
            if (write) sent++;
            cyc();
            n++;
         end
      end
      write = 1'b0; rd_ready = 1'b1;
      for (int c = 0; c < 100 && rd_valid; c++) begin
         chk($sformatf("wrap_data%0d", got), rd_data, 1000 + got);
         chk($sformatf("wrap_last%0d", got), rd_last, (got % 16) == 15);
         got++;
         cyc();
      end
      chk("wrap_count", got, 160);
      chk("wrap_overflow", overflow, 1'b0);
      chk("wrap_blocks", blocks_done, 32'd10);
      chk("wrap_len_err", len_err, 1'b0);

      // Completion: final arrives while five words are buffered.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         write = 1'b1; xin = 500 + i;
         cyc();
      end
      write = 1'b0; seq_final = 1'b1;
      cyc();
      seq_final = 1'b0;
      chk("done_buffered", done, 1'b0);
      rd_ready = 1'b1;
      for (int p = 1; p <= 5; p++) begin
         cyc();
         chk($sformatf("done_after_pop%0d", p), done, p == 5);
      end
      cyc();
      chk("done_holds", done, 1'b1);
      for (int i = 1; i <= 16; i++) begin
         write = 1'b1; xin = 600 + i;
         cyc();
      end
      write = 1'b0;
      cyc();
      chk("done_after_block", done, 1'b1);
      chk("done_block_count", blocks_done, 32'd1);
      rd_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         write = 1'b1; xin = 700 + i;
         cyc();
      end
      chk("pre_reset_valid", rd_valid, 1'b1);
      chk("pre_reset_done", done, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("rst_valid", rd_valid, 1'b0);
      chk("rst_blocks", blocks_done, 32'd0);
      chk("rst_done", done, 1'b0);
      chk("rst_len_err", len_err, 1'b0);
      chk("rst_data", rd_data, 0);
      write = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      chk("rst_final_cleared", done, 1'b0);
      chk("rst_still_empty", rd_valid, 1'b0);

`ifdef RLS_DRAIN_TAG_EN
      do_reset();
      chk("tag_reset", rd_tag, 16'd0);
      rd_ready = 1'b1;
      for (int i = 0; i < 48; i++) begin
         write = 1'b1; xin = 800 + i;
         cyc();
         chk($sformatf("tag%0d", i), rd_tag, i / 16);
      end
      write = 1'b0;
      cyc();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rls_result_drain.md
# rls_result_drain

Receiving end of the RLS coefficient save path. Captures the solution vector words that the RLS control sequencer streams out during its save phase (one word per `write` cycle, N words per system block). Buffers them in a circular store and presents them to a host-side consumer over a valid/ready stream with block-boundary markers. Reports completion once the sequencer signals `final` and the buffer has drained.

## Interface

**Parameters**
- `N`, 16: words per block; a valid save run is exactly N consecutive `write` cycles.
- `W`, 32: data word width.
- `DEPTH`, 64: buffer depth in words; power of 2, ≥ N.

**Ports**
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `write` input 1: word strobe from the sequencer; one word per high cycle.
- `xin` input W: coefficient word, sampled when `write`=1.
- `final` input 1: sequencer has finished all blocks (level).
- `rd_data` output W: head word.
- `rd_valid` output 1: `rd_data` is valid.
- `rd_last` output 1: head word is the N-th word of its block; qualified by `rd_valid`.
- `rd_ready` input 1: consumer accepts the head word when `rd_valid` and `rd_ready` are both 1.
- `blocks_done` output 32: count of complete blocks captured.
- `overflow` output 1: sticky; a word was dropped because the buffer was full.
- `len_err` output 1: sticky; a save run had a length other than N.
- `done` output 1: `final` seen and buffer empty.

## Operation

- Storage: DEPTH×(W+1) array holding the data word plus a last bit. Write pointer and read pointer each log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Capture: on `write`=1 with the buffer not full, store {last, xin} at wptr and increment wptr. `wcnt` counts words in the current run, range 0..N.
  - The last bit is set when the word is the N-th of the run. `wcnt` then returns to 0 and `blocks_done` increments.
- Run-length check:
  - A falling `write` with `wcnt`≠0 sets `len_err` and clears `wcnt`.
  - A run longer than N starts a new block count from word N+1. No error is raised for that case alone.
  - Runs never merge across a low `write` cycle.
- Full: a `write` while occupancy = DEPTH and no simultaneous pop drops the word and sets `overflow`. `wcnt` still advances, so block framing is preserved. If a pop occurs in the same cycle as the write, the write is accepted.
- Read: the head is presented combinationally from the array at rptr. A pop (`rd_valid`&&`rd_ready`) increments rptr.
- Simultaneous push and pop leaves occupancy unchanged. Pushing into an empty buffer causes no same-cycle bypass.
- `done` = `final_seen` && occupancy==0. `final_seen` is a sticky register set by `final`=1.
- Reset: all pointers, counters, and sticky flags clear. Outputs are `rd_valid`=0, `rd_last`=0, `rd_data`=0, `blocks_done`=0, `overflow`=0, `len_err`=0, `done`=0. Array contents are don't-care. Reset mid-run discards the partial block and buffered data.

## Timing

- Capture latency: a word sampled at edge k is visible with `rd_valid`=1 after edge k. It can be popped at edge k+1.
- Throughput: one push and one pop per cycle sustained.
- `blocks_done` updates at the same edge that stores the N-th word.
- `overflow` and `len_err` assert at the offending edge and hold until reset.
- `done` rises in the cycle after the edge that pops the last word, or after the edge that samples `final`, whichever is later. It stays high unless further writes arrive.
- `rd_data` and `rd_last` are stable while `rd_valid`=1 and `rd_ready`=0.

## Configuration

- `RLS_DRAIN_TAG_EN`: when defined, adds an output `rd_tag` [15:0]. It carries the low 16 bits of the block index of the head word; the first block is index 0. The index is stored alongside each word, widening the array to W+17 bits. `rd_tag` resets to 0.
- When `RLS_DRAIN_TAG_EN` is undefined, the port and the extra storage are absent and all other behaviour is identical.

## Test plan

- **Single block, consumer always ready.** Reset, then 1 idle cycle, then 16 `write` cycles with `xin`=1..16. Required response:
  - 16 pops with data 1..16.
  - `rd_last`=1 only on 16.
  - `blocks_done`=1.
  - `len_err`=0.
- **Backpressure to overflow.** `rd_ready`=0, then 4 blocks (64 words), then a 5th block. Required response:
  - Occupancy saturates at 64.
  - `overflow`=1.
  - `blocks_done`=5.
  - After `rd_ready`=1: exactly 64 words drain, in order 1..64 of the first four blocks.
- **Short run.** 10 `write` cycles, then `write` low. Required response: `len_err`=1, `blocks_done`=0. A following 16-word run gives `blocks_done`=1 and `rd_last` on its 16th word.
- **Pointer wrap with concurrent traffic.** `rd_ready` toggling 1/0 across 10 blocks (160 words). Required response:
  - Output sequence matches input exactly.
  - The pointers wrap twice.
  - `overflow` never sets.
- **Completion and reset.** `final`=1 while 5 words are buffered. Required response: `done`=0 until the 5th pop, then `done`=1. Asserting `reset` mid-run clears `done`, `blocks_done`, and `rd_valid` immediately.
- **Tag, with `RLS_DRAIN_TAG_EN` defined.** 3 blocks. Required response: `rd_tag` equals 0, 1, 2 across the respective 16-word groups.
